// File: rtl/issue_sched.sv
// Dependency-matrix issue scheduler: each buffer slot owns a row of producer bits and is
// offered for issue round-robin from rr_ptr once valid, unissued and dependency-free.
module issue_sched #(
    parameter int bs = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alloc_valid,
    input  logic [$clog2(bs)-1:0] alloc_index,
    input  logic [bs-1:0]         alloc_dep,
    input  logic                  cmpl_valid,
    input  logic [$clog2(bs)-1:0] cmpl_index,
    input  logic                  issue_ready,
    output logic                  issue_valid,
    output logic [$clog2(bs)-1:0] issue_index,
    output logic [$clog2(bs):0]   occupancy,
    output logic                  full,
    output logic                  empty,
    output logic                  err
);
    localparam int IW = $clog2(bs);
    localparam int OW = IW + 1;
    localparam logic [bs-1:0] ONE_HOT0 = {{(bs-1){1'b0}}, 1'b1};
    localparam logic [IW-1:0] IDX_ONE  = {{(IW-1){1'b0}}, 1'b1};
    localparam logic [OW-1:0] BS_COUNT = OW'(bs);

    logic [bs-1:0]         valid_r;
    logic [bs-1:0]         issued_r;
    logic [bs-1:0][bs-1:0] row_r;
    logic [IW-1:0]         rr_ptr_r;
    logic [OW-1:0]         occ_r;
    logic                  full_r;
    logic                  empty_r;
    logic                  err_r;

    logic [bs-1:0]         ready_s;
    logic                  sel_found_s;
    logic [IW-1:0]         sel_idx_s;

    logic                  cmpl_ok_s;
    logic [bs-1:0]         cmpl_mask_s;
    logic [bs-1:0]         valid_eff_s;
    logic [bs-1:0]         alloc_mask_s;
    logic                  alloc_ok_s;
    logic                  fire_s;
    logic [bs-1:0]         fire_mask_s;
    logic [bs-1:0]         valid_nx_s;
    logic [bs-1:0]         issued_nx_s;
    logic [bs-1:0][bs-1:0] row_nx_s;
    logic [IW-1:0]         rr_ptr_nx_s;
    logic [OW-1:0]         occ_nx_s;
    logic                  err_nx_s;

    // Per-slot readiness from registered state only.
    always_comb begin
        ready_s = {bs{1'b0}};
        for (int k = 0; k < bs; k++) begin
            ready_s[k] = valid_r[k] & ~issued_r[k] & (row_r[k] == {bs{1'b0}});
        end
    end

    // Round-robin pick: first ready slot at or above rr_ptr, wrapping modulo bs.
    always_comb begin
        logic [IW-1:0] cand_v;
        logic          hit_v;
        sel_found_s = 1'b0;
        sel_idx_s   = {IW{1'b0}};
        cand_v      = {IW{1'b0}};
        hit_v       = 1'b0;
        for (int i = 0; i < bs; i++) begin
            cand_v      = rr_ptr_r + IW'(i);
            hit_v       = ~sel_found_s & ready_s[cand_v];
            sel_idx_s   = hit_v ? cand_v : sel_idx_s;
            sel_found_s = sel_found_s | hit_v;
        end
    end

    // Next-state: completion retires first, so a same-index alloc sees the slot as free.
    always_comb begin
        cmpl_ok_s    = cmpl_valid & valid_r[cmpl_index] & issued_r[cmpl_index];
        cmpl_mask_s  = cmpl_ok_s ? (ONE_HOT0 << cmpl_index) : {bs{1'b0}};
        valid_eff_s  = valid_r & ~cmpl_mask_s;
        alloc_mask_s = ONE_HOT0 << alloc_index;
        alloc_ok_s   = alloc_valid & ~valid_eff_s[alloc_index];
        fire_s       = sel_found_s & issue_ready;
        fire_mask_s  = fire_s ? (ONE_HOT0 << sel_idx_s) : {bs{1'b0}};

        valid_nx_s   = alloc_ok_s ? (valid_eff_s | alloc_mask_s) : valid_eff_s;
        issued_nx_s  = (issued_r & ~cmpl_mask_s) | fire_mask_s;
        issued_nx_s  = alloc_ok_s ? (issued_nx_s & ~alloc_mask_s) : issued_nx_s;

        row_nx_s = row_r;
        for (int k = 0; k < bs; k++) begin
            row_nx_s[k] = (alloc_ok_s && (alloc_index == IW'(k)))
                        ? (alloc_dep & valid_eff_s & ~alloc_mask_s)
                        : (row_r[k] & ~cmpl_mask_s);
        end

        rr_ptr_nx_s = fire_s ? (sel_idx_s + IDX_ONE) : rr_ptr_r;
        occ_nx_s    = occ_r + {{IW{1'b0}}, alloc_ok_s} - {{IW{1'b0}}, cmpl_ok_s};
        err_nx_s    = err_r | (alloc_valid & ~alloc_ok_s) | (cmpl_valid & ~cmpl_ok_s);
    end

    // State and registered status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r  <= {bs{1'b0}};
            issued_r <= {bs{1'b0}};
            row_r    <= {(bs*bs){1'b0}};
            rr_ptr_r <= {IW{1'b0}};
            occ_r    <= {OW{1'b0}};
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
            err_r    <= 1'b0;
        end else begin
            valid_r  <= valid_nx_s;
            issued_r <= issued_nx_s;
            row_r    <= row_nx_s;
            rr_ptr_r <= rr_ptr_nx_s;
            occ_r    <= occ_nx_s;
            full_r   <= (occ_nx_s == BS_COUNT);
            empty_r  <= (occ_nx_s == {OW{1'b0}});
            err_r    <= err_nx_s;
        end
    end

    assign issue_valid = sel_found_s;
    assign issue_index = sel_idx_s;
    assign occupancy   = occ_r;
    assign full        = full_r;
    assign empty       = empty_r;
    assign err         = err_r;

endmodule

// File: tb/tb_issue_sched.sv
// Bench for issue_sched: directed scenarios plus randomized traffic checked against
// a slot-level reference model of the scheduling rules.
module tb_issue_sched;
    localparam int BS = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        alloc_valid = 1'b0;
    logic [3:0]  alloc_index = 4'd0;
    logic [15:0] alloc_dep = 16'h0000;
    logic        cmpl_valid = 1'b0;
    logic [3:0]  cmpl_index = 4'd0;
    logic        issue_ready = 1'b0;
    logic        issue_valid;
    logic [3:0]  issue_index;
    logic [4:0]  occupancy;
    logic        full, empty, err;

    int n_vec = 0;
    int n_bad = 0;

    // reference model state
    bit m_valid [BS];
    bit m_issued[BS];
    bit m_dep   [BS][BS];
    int m_rr;
    bit m_err;

    always #5 clk = ~clk;

    issue_sched #(.bs(BS)) dut (
        .clk(clk), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_index(alloc_index), .alloc_dep(alloc_dep),
        .cmpl_valid(cmpl_valid), .cmpl_index(cmpl_index), .issue_ready(issue_ready),
        .issue_valid(issue_valid), .issue_index(issue_index), .occupancy(occupancy),
        .full(full), .empty(empty), .err(err)
    );

    function automatic void m_reset();
        for (int k = 0; k < BS; k++) begin
            m_valid[k] = 0; m_issued[k] = 0;
            for (int j = 0; j < BS; j++) m_dep[k][j] = 0;
        end
        m_rr = 0; m_err = 0;
    endfunction

    function automatic bit m_ready(int k);
        bit r = m_valid[k] && !m_issued[k];
        for (int j = 0; j < BS; j++) if (m_dep[k][j]) r = 0;
        return r;
    endfunction

    function automatic void m_offer(output bit v, output int idx);
        v = 0; idx = 0;
        for (int i = 0; i < BS; i++) begin
            int k = (m_rr + i) % BS;
            if (!v && m_ready(k)) begin v = 1; idx = k; end
        end
    endfunction

    function automatic int m_count();
        int c = 0;
        for (int k = 0; k < BS; k++) c += m_valid[k];
        return c;
    endfunction

    function automatic void m_step(bit av, int ai, logic [15:0] ad, bit cv, int ci, bit rdy);
        bit ov, cok, aok;
        int oi;
        m_offer(ov, oi);
        cok = cv && m_valid[ci] && m_issued[ci];
        if (cv && !cok) m_err = 1;
        aok = av && (!m_valid[ai] || (cok && ci == ai));
        if (av && !aok) m_err = 1;
        if (cok) begin
            m_valid[ci] = 0; m_issued[ci] = 0;
            for (int k = 0; k < BS; k++) m_dep[k][ci] = 0;
        end
        if (ov && rdy) begin m_issued[oi] = 1; m_rr = (oi + 1) % BS; end
        if (aok) begin
            m_valid[ai] = 1; m_issued[ai] = 0;
            for (int j = 0; j < BS; j++) m_dep[ai][j] = ad[j] && m_valid[j] && (j != ai);
        end
    endfunction

    // One clock: drive inputs, advance the model, sample 1 time unit after the edge.
    task automatic cyc(input bit av, input int ai, input logic [15:0] ad,
                       input bit cv, input int ci, input bit rdy);
        alloc_valid = av; alloc_index = ai[3:0]; alloc_dep = ad;
        cmpl_valid = cv; cmpl_index = ci[3:0]; issue_ready = rdy;
        m_step(av, ai, ad, cv, ci, rdy);
        @(posedge clk); #1;
        alloc_valid = 1'b0; cmpl_valid = 1'b0; issue_ready = 1'b0; alloc_dep = 16'h0000;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        m_reset();
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        n_vec++; if (issue_valid !== 1'b0) begin n_bad++; $display("FAIL rst_issue_valid got %0b want 0", issue_valid); end
        n_vec++; if (issue_index !== 4'd0) begin n_bad++; $display("FAIL rst_issue_index got %0d want 0", issue_index); end
        n_vec++; if (occupancy !== 5'd0) begin n_bad++; $display("FAIL rst_occupancy got %0d want 0", occupancy); end
        n_vec++; if (full !== 1'b0) begin n_bad++; $display("FAIL rst_full got %0b want 0", full); end
        n_vec++; if (empty !== 1'b1) begin n_bad++; $display("FAIL rst_empty got %0b want 1", empty); end
        n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL rst_err got %0b want 0", err); end
        m_reset();
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_single_alloc();
        do_reset();
        cyc(1, 3, 16'h0000, 0, 0, 0);
        n_vec++; if (issue_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid got %0b want 1", issue_valid); end
        n_vec++; if (issue_index !== 4'd3) begin n_bad++; $display("FAIL single_index got %0d want 3", issue_index); end
        n_vec++; if (occupancy !== 5'd1) begin n_bad++; $display("FAIL single_occ got %0d want 1", occupancy); end
        n_vec++; if (empty !== 1'b0) begin n_bad++; $display("FAIL single_empty got %0b want 0", empty); end
    endtask

    task automatic test_dependency();
        do_reset();
        cyc(1, 0, 16'h0000, 0, 0, 0);
        cyc(1, 1, 16'h0001, 0, 0, 1);
        n_vec++; if (issue_valid !== 1'b0) begin n_bad++; $display("FAIL dep_blocked got %0b want 0", issue_valid); end
        n_vec++; if (occupancy !== 5'd2) begin n_bad++; $display("FAIL dep_occ got %0d want 2", occupancy); end
        cyc(0, 0, 16'h0000, 1, 0, 0);
        n_vec++; if (issue_valid !== 1'b1) begin n_bad++; $display("FAIL dep_wake_valid got %0b want 1", issue_valid); end
        n_vec++; if (issue_index !== 4'd1) begin n_bad++; $display("FAIL dep_wake_index got %0d want 1", issue_index); end
        n_vec++; if (occupancy !== 5'd1) begin n_bad++; $display("FAIL dep_wake_occ got %0d want 1", occupancy); end
    endtask

    task automatic test_round_robin();
        int want[3] = '{2, 5, 16};
        do_reset();
        cyc(1, 5, 16'h0000, 0, 0, 0);
        cyc(0, 0, 16'h0000, 0, 0, 1);
        cyc(0, 0, 16'h0000, 1, 5, 0);
        cyc(1, 2, 16'h0000, 0, 0, 0);
        cyc(1, 5, 16'h0000, 0, 0, 0);
        cyc(1, 14, 16'h0000, 0, 0, 0);
        n_vec++; if (issue_index !== 4'd14) begin n_bad++; $display("FAIL rr_first got %0d want 14", issue_index); end
        for (int s = 0; s < 3; s++) begin
            cyc(0, 0, 16'h0000, 0, 0, 1);
            n_vec++;
            if ((want[s] == 16 && issue_valid !== 1'b0) ||
                (want[s] != 16 && (issue_valid !== 1'b1 || int'(issue_index) != want[s]))) begin
                n_bad++; $display("FAIL rr_step%0d got valid=%0b idx=%0d want %0d (16=none)", s, issue_valid, issue_index, want[s]);
            end
        end
        cyc(1, 4, 16'h0000, 0, 0, 0);
        cyc(1, 7, 16'h0000, 0, 0, 0);
        n_vec++; if (issue_index !== 4'd7) begin n_bad++; $display("FAIL rr_ptr_end got %0d want 7", issue_index); end
        n_vec++; if (occupancy !== 5'd5) begin n_bad++; $display("FAIL rr_occ got %0d want 5", occupancy); end
    endtask

    task automatic test_dep_mask();
        do_reset();
        cyc(1, 4, 16'h0110, 0, 0, 0);
        n_vec++; if (issue_valid !== 1'b1 || issue_index !== 4'd4) begin n_bad++; $display("FAIL mask_self got valid=%0b idx=%0d want 1/4", issue_valid, issue_index); end
        cyc(1, 8, 16'h0000, 0, 0, 0);
        cyc(1, 2, 16'h0110, 0, 0, 0);
        n_vec++; if (issue_index !== 4'd4) begin n_bad++; $display("FAIL mask_retain got %0d want 4", issue_index); end
        cyc(0, 0, 16'h0000, 0, 0, 1);
        n_vec++; if (issue_index !== 4'd8) begin n_bad++; $display("FAIL mask_after_issue got %0d want 8", issue_index); end
    endtask

    task automatic test_full_err();
        do_reset();
        for (int i = 0; i < BS; i++) begin
            cyc(1, i, 16'h0000, 0, 0, 0);
            if (i == BS - 2) begin
                n_vec++; if (full !== 1'b0) begin n_bad++; $display("FAIL full_early got %0b want 0", full); end
            end
        end
        n_vec++; if (full !== 1'b1) begin n_bad++; $display("FAIL full_flag got %0b want 1", full); end
        n_vec++; if (occupancy !== 5'd16) begin n_bad++; $display("FAIL full_occ got %0d want 16", occupancy); end
        n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL full_err_clean got %0b want 0", err); end
        cyc(1, 7, 16'h0000, 0, 0, 0);
        n_vec++; if (err !== 1'b1) begin n_bad++; $display("FAIL dup_alloc_err got %0b want 1", err); end
        n_vec++; if (occupancy !== 5'd16) begin n_bad++; $display("FAIL dup_alloc_occ got %0d want 16", occupancy); end
        cyc(0, 0, 16'h0000, 1, 3, 0);
        n_vec++; if (occupancy !== 5'd16) begin n_bad++; $display("FAIL bad_cmpl_occ got %0d want 16", occupancy); end
        n_vec++; if (issue_valid !== 1'b1 || issue_index !== 4'd0) begin n_bad++; $display("FAIL bad_cmpl_offer got valid=%0b idx=%0d want 1/0", issue_valid, issue_index); end
        cyc(0, 0, 16'h0000, 0, 0, 0);
        n_vec++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_sticky got %0b want 1", err); end
    endtask

    task automatic test_same_cycle_and_reset();
        do_reset();
        cyc(1, 9, 16'h0000, 0, 0, 0);
        cyc(0, 0, 16'h0000, 0, 0, 1);
        cyc(1, 9, 16'h0000, 1, 9, 0);
        n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL same_err got %0b want 0", err); end
        n_vec++; if (occupancy !== 5'd1) begin n_bad++; $display("FAIL same_occ got %0d want 1", occupancy); end
        n_vec++; if (issue_valid !== 1'b1 || issue_index !== 4'd9) begin n_bad++; $display("FAIL same_realloc got valid=%0b idx=%0d want 1/9", issue_valid, issue_index); end
        rst = 1'b1;
        #1;
        n_vec++; if (issue_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_valid got %0b want 0", issue_valid); end
        n_vec++; if (empty !== 1'b1 || occupancy !== 5'd0) begin n_bad++; $display("FAIL midrst_empty got empty=%0b occ=%0d want 1/0", empty, occupancy); end
        m_reset();
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        cyc(1, 1, 16'h0000, 0, 0, 0);
        n_vec++; if (issue_index !== 4'd1 || occupancy !== 5'd1) begin n_bad++; $display("FAIL post_rst_alloc got idx=%0d occ=%0d want 1/1", issue_index, occupancy); end
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            do_reset();
            for (int c = 0; c < 120; c++) begin
                bit av, cv, rdy, found, ev;
                int ai, ci, ei;
                logic [15:0] ad;
                av = ($urandom_range(0, 9) < 6);
                cv = ($urandom_range(0, 9) < 4);
                rdy = ($urandom_range(0, 3) != 0);
                ad = 16'($urandom & $urandom & $urandom);
                ci = $urandom_range(0, BS - 1);
                if ($urandom_range(0, 39) != 0) begin
                    found = 0;
                    for (int t = 0; t < BS; t++) begin
                        int k = (ci + t) % BS;
                        if (!found && m_issued[k]) begin found = 1; ci = k; end
                    end
                    if (!found) cv = 0;
                end
                ai = $urandom_range(0, BS - 1);
                if ($urandom_range(0, 39) != 0) begin
                    found = 0;
                    for (int t = 0; t < BS; t++) begin
                        int k = (ai + t) % BS;
                        if (!found && !m_valid[k]) begin found = 1; ai = k; end
                    end
                    if (!found) av = 0;
                    if (cv && m_issued[ci] && $urandom_range(0, 7) == 0) begin av = 1; ai = ci; end
                end
                cyc(av, ai, ad, cv, ci, rdy);
                m_offer(ev, ei);
                n_vec++; if (issue_valid !== ev) begin n_bad++; $display("FAIL rnd_valid r%0d c%0d got %0b want %0b", r, c, issue_valid, ev); end
                n_vec++; if (int'(issue_index) != ei) begin n_bad++; $display("FAIL rnd_index r%0d c%0d got %0d want %0d", r, c, issue_index, ei); end
                n_vec++; if (int'(occupancy) != m_count()) begin n_bad++; $display("FAIL rnd_occ r%0d c%0d got %0d want %0d", r, c, occupancy, m_count()); end
                n_vec++; if (full !== (m_count() == BS)) begin n_bad++; $display("FAIL rnd_full r%0d c%0d got %0b", r, c, full); end
                n_vec++; if (empty !== (m_count() == 0)) begin n_bad++; $display("FAIL rnd_empty r%0d c%0d got %0b", r, c, empty); end
                n_vec++; if (err !== m_err) begin n_bad++; $display("FAIL rnd_err r%0d c%0d got %0b want %0b", r, c, err, m_err); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_alloc();
        test_dependency();
        test_round_robin();
        test_dep_mask();
        test_full_err();
        test_same_cycle_and_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/issue_sched.md
ISSUE_SCHED -- requirements
Module: issue_sched

Interface
REQ-001 Parameter: bs, default 16, instruction-buffer slot count (power of two, >=2); each slot owns one row and one column of the dependency matrix.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 alloc_valid  input  1  new instruction written into a slot this cycle.
REQ-005 alloc_index  input  $clog2(bs)  slot receiving the new instruction.
REQ-006 alloc_dep  input  bs  dependency vector for the new instruction, same cycle as alloc_valid; bit k set = depends on slot k.
REQ-007 cmpl_valid  input  1  an issued instruction finished this cycle.
REQ-008 cmpl_index  input  $clog2(bs)  slot of the finished instruction.
REQ-009 issue_ready  input  1  execution side accepts the offered instruction.
REQ-010 issue_valid  output  1  a dependency-free, unissued slot is offered.
REQ-011 issue_index  output  $clog2(bs)  offered slot; 0 when issue_valid=0.
REQ-012 occupancy  output  $clog2(bs)+1  number of valid slots.
REQ-013 full  output  1  occupancy==bs.  empty  output  1  occupancy==0.
REQ-014 err  output  1  sticky protocol-violation flag.

Function
REQ-015 State: valid[bs], issued[bs], dep matrix row[bs][bs], rr_ptr $clog2(bs), err.
REQ-016 Slot k ready = valid[k] & ~issued[k] & (row[k]==0).
REQ-017 Selection: first ready slot scanning upward from rr_ptr, wrapping bs-1 -> 0; issue_valid/issue_index combinational from registered state only (no input-to-output path).
REQ-018 Handshake: issue fires when issue_valid & issue_ready; next cycle issued[issue_index]=1, rr_ptr=(issue_index+1) mod bs; issue_valid may drop or advance to another slot.
REQ-019 issue_valid & ~issue_ready: offer may change only if a higher-priority slot becomes ready; no state change to issued/rr_ptr.
REQ-020 Alloc to slot with valid=0: next cycle valid=1, issued=0, row = alloc_dep & valid_eff & ~(1<<alloc_index), where valid_eff = valid with completing slot cleared.
REQ-021 Alloc to slot with valid=1 and not completing same cycle: ignored, err set.
REQ-022 Completion of slot with valid=1 & issued=1: next cycle valid=0, issued=0, column cmpl_index cleared in every row.
REQ-023 Completion of slot not valid or not issued: ignored, err set.
REQ-024 Same cycle alloc and completion, same index: completion applies first, alloc accepted, err not set.
REQ-025 Same cycle issue fire and completion of other slot: both take effect.
REQ-026 Newly allocated slot is never ready in its allocation cycle; earliest issue_valid for it is the following cycle.
REQ-027 occupancy updated every cycle: +1 accepted alloc, -1 accepted completion, net 0 when both.
REQ-028 Issued slots stay valid and counted until completion; rows of other slots keep their bit until then.

Reset
REQ-029 rst=1 asynchronously clears valid, issued, all matrix bits, rr_ptr=0, err=0; outputs immediately issue_valid=0, issue_index=0, occupancy=0, full=0, empty=1.
REQ-030 Reset mid-operation discards all in-flight slots; no completion is expected for them afterward.
REQ-031 Inputs ignored while rst=1; first accepted alloc is on the first rising edge after rst deasserts.

Verification
REQ-032 Reset, then alloc slot 3 with alloc_dep=0 -> next cycle issue_valid=1, issue_index=3, occupancy=1, empty=0.
REQ-033 Alloc slot 0 dep=0, then slot 1 dep=0x0001; issue_ready=1 -> slot 0 issues, slot 1 not offered; cmpl slot 0 -> next cycle issue_valid=1, issue_index=1.
REQ-034 Slots 2,5,14 ready, rr_ptr=6 -> issue order 14, 2, 5 with issue_ready held high; rr_ptr ends 6.
REQ-035 Alloc slot 4 with dep=0x0110 while slot 8 invalid and slot 4 self bit set -> stored row 0x0000 ... only valid slots retained; slot 4 ready next cycle.
REQ-036 Fill all 16 slots -> full=1, occupancy=16; alloc to occupied slot 7 -> err=1 sticky, occupancy stays 16; cmpl of unissued slot -> err remains 1, no state change.
REQ-037 Alloc and cmpl of slot 9 same cycle -> slot 9 re-allocated, err=0, occupancy unchanged; assert rst mid-stream -> issue_valid=0, empty=1 immediately.
